// File: rtl/mem_port_arbiter.sv
// Serialises byte-wide client strobes onto one 16-bit toggle-handshake SDRAM port,
// with per-client request buffers, fixed or round-robin priority and read-return registers.
module mem_port_arbiter #(
  parameter int NCLI = 3,
  parameter int AW   = 17,
  parameter int RR   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCLI-1:0]    cli_cs,
  input  logic [NCLI-1:0]    cli_rd,
  input  logic [NCLI-1:0]    cli_we,
  input  logic [NCLI*AW-1:0] cli_addr,
  input  logic [NCLI*8-1:0]  cli_din,
  output logic [NCLI*8-1:0]  cli_q,
  output logic [NCLI-1:0]    cli_busy,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic [AW-2:0]      mem_a,
  output logic [1:0]         mem_ds,
  output logic               mem_we,
  output logic [15:0]        mem_d,
  input  logic [15:0]        mem_q
);

  localparam int SW = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [NCLI-1:0] ev;

  // Per-client edge/address-change detection against last cycle's strobes.
  for (genvar gi = 0; gi < NCLI; gi++) begin : g_cli
    logic [AW-1:0] addr_w;
    logic          rd_w, we_w;
    logic          rd_hist_q, rd_hist_d;
    logic          we_hist_q, we_hist_d;
    logic [AW-1:0] addr_hist_q, addr_hist_d;

    assign addr_w = cli_addr[gi*AW +: AW];
    assign rd_w   = cli_cs[gi] & cli_rd[gi];
    assign we_w   = cli_cs[gi] & cli_we[gi];
    assign ev[gi] = (rd_w & ~rd_hist_q) | (we_w & ~we_hist_q) |
                    ((rd_w | we_w) & (addr_w != addr_hist_q));

    always_comb begin
      rd_hist_d   = rd_w;
      we_hist_d   = we_w;
      addr_hist_d = addr_w;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_hist_q   <= 1'b0;
        we_hist_q   <= 1'b0;
        addr_hist_q <= '0;
      end else begin
        rd_hist_q   <= rd_hist_d;
        we_hist_q   <= we_hist_d;
        addr_hist_q <= addr_hist_d;
      end
    end
  end

  logic [0:0]         state_q, state_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [SW-1:0]      rr_q, rr_d;
  logic               lsb_q, lsb_d;
  logic [NCLI-1:0]    pend_q, pend_d;
  logic [AW-1:0]      buf_addr_q [NCLI];
  logic [AW-1:0]      buf_addr_d [NCLI];
  logic [7:0]         buf_din_q [NCLI];
  logic [7:0]         buf_din_d [NCLI];
  logic [NCLI-1:0]    buf_we_q, buf_we_d;
  logic               mem_req_q, mem_req_d;
  logic [AW-2:0]      mem_a_q, mem_a_d;
  logic [1:0]         mem_ds_q, mem_ds_d;
  logic               mem_we_q, mem_we_d;
  logic [15:0]        mem_d_q, mem_d_d;
  logic [NCLI*8-1:0]  ret_q, ret_d;
  logic [SW-1:0]      pick;

  // Descending scans so the first candidate in priority order is the last one written.
  always_comb begin
    pick = '0;
    if (RR == 0) begin
      for (int i = NCLI - 1; i >= 0; i--) begin
        if (pend_q[i]) pick = SW'(i);
      end
    end else begin
      for (int k = NCLI; k >= 1; k--) begin
        if (pend_q[(int'(rr_q) + k) % NCLI]) pick = SW'((int'(rr_q) + k) % NCLI);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    lsb_d      = lsb_q;
    pend_d     = pend_q;
    buf_addr_d = buf_addr_q;
    buf_din_d  = buf_din_q;
    buf_we_d   = buf_we_q;
    mem_req_d  = mem_req_q;
    mem_a_d    = mem_a_q;
    mem_ds_d   = mem_ds_q;
    mem_we_d   = mem_we_q;
    mem_d_d    = mem_d_q;
    ret_d      = ret_q;

    case (state_q)
      S_IDLE: begin
        if ((mem_ack == mem_req_q) && (|pend_q)) begin
          sel_d        = pick;
          lsb_d        = buf_addr_q[pick][0];
          mem_a_d      = buf_addr_q[pick][AW-1:1];
          mem_we_d     = buf_we_q[pick];
          mem_ds_d     = buf_we_q[pick] ? (buf_addr_q[pick][0] ? 2'b10 : 2'b01) : 2'b11;
          mem_d_d      = {buf_din_q[pick], buf_din_q[pick]};
          mem_req_d    = ~mem_req_q;
          pend_d[pick] = 1'b0;
          state_d      = S_WAIT;
        end
      end
      default: begin
        if (mem_ack == mem_req_q) begin
          if (!mem_we_q) begin
            for (int i = 0; i < NCLI; i++) begin
              if (sel_q == SW'(i)) ret_d[i*8 +: 8] = lsb_q ? mem_q[15:8] : mem_q[7:0];
            end
          end
          rr_d    = sel_q;
          state_d = S_IDLE;
        end
      end
    endcase

    // A fresh event wins over the clear from an issue in the same cycle.
    for (int i = 0; i < NCLI; i++) begin
      if (ev[i]) begin
        buf_addr_d[i] = cli_addr[i*AW +: AW];
        buf_din_d[i]  = cli_din[i*8 +: 8];
        buf_we_d[i]   = cli_we[i];
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      rr_q      <= SW'(NCLI - 1);
      lsb_q     <= 1'b0;
      pend_q    <= '0;
      buf_we_q  <= '0;
      mem_req_q <= 1'b0;
      mem_a_q   <= '0;
      mem_ds_q  <= 2'b11;
      mem_we_q  <= 1'b0;
      mem_d_q   <= '0;
      ret_q     <= '0;
      for (int i = 0; i < NCLI; i++) begin
        buf_addr_q[i] <= '0;
        buf_din_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      lsb_q      <= lsb_d;
      pend_q     <= pend_d;
      buf_we_q   <= buf_we_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      mem_ds_q   <= mem_ds_d;
      mem_we_q   <= mem_we_d;
      mem_d_q    <= mem_d_d;
      ret_q      <= ret_d;
      buf_addr_q <= buf_addr_d;
      buf_din_q  <= buf_din_d;
    end
  end

  always_comb begin
    cli_busy = pend_q;
    if (state_q == S_WAIT) begin
      for (int i = 0; i < NCLI; i++) begin
        if (sel_q == SW'(i)) cli_busy[i] = 1'b1;
      end
    end
  end

  assign cli_q   = ret_q;
  assign mem_req = mem_req_q;
  assign mem_a   = mem_a_q;
  assign mem_ds  = mem_ds_q;
  assign mem_we  = mem_we_q;
  assign mem_d   = mem_d_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the ad-hoc SDRAM port-1 request logic in the core top level.
- Turns N byte-wide client strobes (CPU RAM, ROM, ROM download, tape, ...) into serialised requests on one 16-bit toggle-handshake SDRAM port.
- Per-client request buffering, selectable fixed/round-robin priority, and per-client read-data return registers.
- Sits between the machine core / data_io and the sdram controller, in the SDRAM clock domain.

Parameters:
- NCLI, 3, number of clients.
- AW, 17, client byte-address width; SDRAM word address is AW-1 bits.
- RR, 0, priority mode: 0 = fixed (lowest index wins), 1 = round-robin starting after the last served client.

Ports:
- clk  in  1  SDRAM-domain clock.
- reset  in  1  asynchronous, active-high reset.
- cli_cs  in  NCLI  per-client select.
- cli_rd  in  NCLI  per-client read enable.
- cli_we  in  NCLI  per-client write enable.
- cli_addr  in  NCLI*AW  per-client byte address; client i occupies [i*AW +: AW].
- cli_din  in  NCLI*8  per-client write byte.
- cli_q  out  NCLI*8  per-client last read byte.
- cli_busy  out  NCLI  client has a pending or in-flight request.
- mem_req  out  1  toggle request to SDRAM port.
- mem_ack  in  1  toggle acknowledge; same clock domain.
- mem_a  out  AW-1  word address (byte addr[AW-1:1]).
- mem_ds  out  2  byte strobes: write addr[0]=1 -> 2'b10, addr[0]=0 -> 2'b01; read -> 2'b11.
- mem_we  out  1  write request.
- mem_d  out  16  {din,din}.
- mem_q  in  16  read word, valid when mem_ack==mem_req.

Behaviour:
- Reset (async): mem_req=0, mem_we=0, mem_ds=2'b11, mem_a=0, mem_d=0, cli_q=0, cli_busy=0, all pending=0, state IDLE, rr pointer=NCLI-1, edge-detect history=0.
- Event for client i, sampled each edge, any of:
  - rising edge of cs&rd;
  - rising edge of cs&we;
  - cs&(rd|we) with addr differing from the previous cycle's addr.
- On an event, client i's buffer latches addr, we, din and sets pending[i].
- A new event on a pending, not-yet-issued client overwrites its buffer (last wins).
- cli_busy[i] = pending[i] | (in-flight and sel==i).
- FSM IDLE:
  - Issue only if mem_ack==mem_req; a port left busy by reset is waited out.
  - If any pending, choose sel per RR mode, drive mem_a/mem_ds/mem_we/mem_d from buf[sel], toggle mem_req, clear pending[sel], go WAIT.
  - Issue edge is the edge after pending becomes visible, so event-to-mem_req-toggle latency is 2 clocks when the port is idle.
- FSM WAIT:
  - Hold all mem_* outputs stable.
  - On the first edge with mem_ack==mem_req: if !we, cli_q[sel] <= addr[0] ? mem_q[15:8] : mem_q[7:0]; update rr pointer to sel; go IDLE.
  - At most one request in flight.
- An event on the in-flight client during WAIT sets pending again; that request is re-issued after completion and never merged.
- Simultaneous events on several clients all become pending in the same cycle and are served in priority order, one per handshake.
- RR=0: lower index always preempts in IDLE, so higher clients may starve; this is intended, and the download client must be index 0.
- Events on clients with cs=0 are ignored. Deasserting cs does not cancel a pending request.
- Reset mid-WAIT: the transaction is abandoned, cli_q is not updated, and mem_req returns to 0 immediately.

Test Plan:
- Single read: client 1 addr=0x1_0005, cs&rd rises; mem model acks 4 clocks later with mem_q=0xA55A -> mem_req toggles 2 clocks after the event, mem_a=0x8002, mem_ds=2'b11, cli_q[1]=0xA5, cli_busy[1] falls the cycle after the ack.
- Write lane: client 0 write addr=0x00010, din=0x3C -> mem_we=1, mem_ds=2'b01, mem_d=0x3C3C; same with addr=0x00011 -> mem_ds=2'b10; cli_q unchanged.
- Contention: clients 0, 1, 2 all have events in the same cycle, RR=0 -> service order 0,1,2; with RR=1 and last served=1 -> order 2,0,1.
- Address streaming: client 2 holds cs&rd and changes addr every 3 clocks while acks take 6 clocks -> every distinct address that was pending at issue time is issued, intermediate overwritten addresses are dropped, and there are no duplicate requests.
- Re-issue: new event on the in-flight client during WAIT -> a second request for the new addr follows immediately after the ack.
- Reset mid-WAIT with mem model holding ack!=req -> after reset no request is issued until mem_ack returns to 0, then pending traffic resumes correctly.
